alm_dot_accumulator: RTL and testbench
======================================

ALM_DOT_ACCUMULATOR -- requirements
Module: alm_dot_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator and result width in bits (legal range 32..48).
REQ-002 SHALL have parameter LEN_W, default 8, width of the vector-length input.
REQ-003 SHALL have i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have i_start  input  1  single-cycle request to begin a new vector.
REQ-006 SHALL have i_len  input  LEN_W  element count, unsigned, sampled with i_start.
REQ-007 SHALL have o_busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have i_p_valid / o_p_ready / i_p_data  input / output / input  1 / 1 / 32 (signed)  product stream from the log multiplier.
REQ-009 SHALL have o_s_valid / i_s_ready / o_s_data  output / input / output  1 / 1 / ACC_W (signed)  result stream.
REQ-010 SHALL have o_s_ovf  output  1  overflow flag qualified by o_s_valid.

Function
REQ-011 SHALL implement states IDLE, ACC, DONE.
REQ-012 In IDLE, i_start with i_len!=0 SHALL clear the accumulator, load remaining=i_len, enter ACC next cycle.
REQ-013 In IDLE, i_start with i_len==0 SHALL enter DONE next cycle with o_s_data=0, o_s_ovf=0.
REQ-014 i_start outside IDLE SHALL be ignored with no effect on state or data.
REQ-015 o_p_ready SHALL be 1 exactly in ACC; a beat transfers when i_p_valid and o_p_ready are both 1.
REQ-016 Each transferred beat SHALL add sign-extended i_p_data to the accumulator and decrement remaining; throughput one beat per cycle.
REQ-017 The beat transferred while remaining==1 SHALL move state to DONE in the next cycle; o_s_data SHALL then equal the full sum (latency 1 cycle from last beat).
REQ-018 In DONE, o_s_valid SHALL be 1 and o_s_data/o_s_ovf SHALL be held stable until i_s_ready; on handshake state SHALL return to IDLE next cycle.
REQ-019 i_p_valid while not in ACC SHALL not alter the accumulator.
REQ-020 i_s_ready while not in DONE SHALL have no effect.

Reset
REQ-021 Asserting i_rst_n low SHALL immediately force state IDLE, accumulator 0, remaining 0, o_busy 0, o_p_ready 0, o_s_valid 0, o_s_data 0, o_s_ovf 0, including mid-vector; the partial sum SHALL be discarded.
REQ-022 After release, the first i_start SHALL be accepted no earlier than the first rising edge with i_rst_n high.

Configuration
REQ-023 Macro ALM_ACC_SAT_EN defined: each addition SHALL be computed at ACC_W+1 bits; on overflow the accumulator SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and a sticky flag SHALL set, cleared at vector start, driven on o_s_ovf.
REQ-024 Macro ALM_ACC_SAT_EN undefined: addition SHALL wrap modulo 2^ACC_W and o_s_ovf SHALL be constant 0.

Structure
REQ-025 Package alm_acc_pkg SHALL hold the state enum type and constant PROD_W=32.
REQ-026 The adder with optional saturation SHALL be a sub-module alm_sat_add (parameter ACC_W), the only instantiated child.

Verification
REQ-027 start len=4, products 100, -50, 7, 0 back-to-back -> o_s_valid one cycle after 4th beat, o_s_data=57, o_s_ovf=0.
REQ-028 start len=0 -> next cycle DONE, o_s_data=0; no o_p_ready pulse.
REQ-029 len=3 with i_p_valid gaps and i_s_ready held low 5 cycles -> sum correct, o_s_data stable throughout stall, IDLE one cycle after ready.
REQ-030 ACC_W=32, len=3, products 0x40000000 each: with ALM_ACC_SAT_EN -> o_s_data=0x7FFFFFFF, o_s_ovf=1; without -> o_s_data=0xC0000000 (wrapped), o_s_ovf=0.
REQ-031 reset asserted after 2 of 4 beats -> all outputs 0 immediately; new start len=1, product -1 -> o_s_data=-1.
REQ-032 i_start pulsed during ACC and DONE -> ignored; result equals original vector sum.

Source files
------------

// File: rtl/alm_acc_pkg.sv
// ============================================================================
// Module      : alm_acc_pkg
// Description : Shared types and constants for the dot-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alm_acc_pkg;

    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/alm_sat_add.sv
// ============================================================================
// Module      : alm_sat_add
// Description : Accumulator + sign-extended product adder. With ALM_ACC_SAT_EN
//               defined the sum clamps to the signed range and flags overflow;
//               otherwise it wraps and the flag is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alm_sat_add
    import alm_acc_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0]  i_a,
    input  logic [PROD_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic signed [ACC_W-1:0] w_b_ext;
    assign w_b_ext = ACC_W'($signed(i_b));

`ifdef ALM_ACC_SAT_EN
    localparam logic [ACC_W-1:0] c_sat_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_sat_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] w_wide;

    // One guard bit: overflow whenever the top two bits of the wide sum differ.
    assign w_wide = (ACC_W+1)'($signed(i_a)) + (ACC_W+1)'(w_b_ext);
    assign o_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign o_sum  = o_ovf ? (w_wide[ACC_W] ? c_sat_min : c_sat_max)
                          : w_wide[ACC_W-1:0];
`else
    assign o_sum = i_a + w_b_ext;
    assign o_ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/alm_dot_accumulator.sv
// ============================================================================
// Module      : alm_dot_accumulator
// Description : Sums a length-prefixed stream of signed products and presents
//               the result on a valid/ready port. Optional saturation is
//               enabled with the ALM_ACC_SAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alm_dot_accumulator
    import alm_acc_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    input  logic              i_p_valid,
    output logic              o_p_ready,
    input  logic [PROD_W-1:0] i_p_data,
    output logic              o_s_valid,
    input  logic              i_s_ready,
    output logic [ACC_W-1:0]  o_s_data,
    output logic              o_s_ovf
);

    acc_state_t       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_rem;
    logic             r_ovf;
    logic             r_busy;
    logic             r_p_ready;
    logic             r_s_valid;

    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_beat;

    assign w_beat = i_p_valid & r_p_ready;

    alm_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (i_p_data),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // Handshake flags are registered alongside the state so they never glitch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_rem     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_p_ready <= 1'b0;
            r_s_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_len != '0) begin
                            r_rem     <= i_len;
                            r_state   <= ST_ACC;
                            r_p_ready <= 1'b1;
                        end else begin
                            r_rem     <= '0;
                            r_state   <= ST_DONE;
                            r_s_valid <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_add_ovf;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == LEN_W'(1)) begin
                            r_state   <= ST_DONE;
                            r_p_ready <= 1'b0;
                            r_s_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_s_ready) begin
                        r_state   <= ST_IDLE;
                        r_s_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_acc     <= '0;
                    r_rem     <= '0;
                    r_ovf     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_p_ready <= 1'b0;
                    r_s_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_p_ready = r_p_ready;
    assign o_s_valid = r_s_valid;
    assign o_s_data  = r_acc;
    assign o_s_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_alm_dot_accumulator.sv
// ============================================================================
// Module      : tb_alm_dot_accumulator
// Description : Scoreboard bench driving a 40-bit and a 32-bit accumulator
//               with identical directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alm_dot_accumulator;

    typedef struct packed {
        logic [39:0] d40;
        logic [31:0] d32;
        logic        ovf32;
    } exp_t;

    logic        clk;
    logic        r_rst_n;
    logic        r_start;
    logic [7:0]  r_len;
    logic        r_p_valid;
    logic [31:0] r_p_data;
    logic        r_s_ready;

    logic        a_busy, a_p_ready, a_s_valid, a_s_ovf;
    logic [39:0] a_s_data;
    logic        b_busy, b_p_ready, b_s_valid, b_s_ovf;
    logic [31:0] b_s_data;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    alm_dot_accumulator u_dut40 (
        .i_clk     (clk),
        .i_rst_n   (r_rst_n),
        .i_start   (r_start),
        .i_len     (r_len),
        .o_busy    (a_busy),
        .i_p_valid (r_p_valid),
        .o_p_ready (a_p_ready),
        .i_p_data  (r_p_data),
        .o_s_valid (a_s_valid),
        .i_s_ready (r_s_ready),
        .o_s_data  (a_s_data),
        .o_s_ovf   (a_s_ovf)
    );

    alm_dot_accumulator #(
        .ACC_W (32),
        .LEN_W (8)
    ) u_dut32 (
        .i_clk     (clk),
        .i_rst_n   (r_rst_n),
        .i_start   (r_start),
        .i_len     (r_len),
        .o_busy    (b_busy),
        .i_p_valid (r_p_valid),
        .o_p_ready (b_p_ready),
        .i_p_data  (r_p_data),
        .o_s_valid (b_s_valid),
        .i_s_ready (r_s_ready),
        .o_s_data  (b_s_data),
        .o_s_ovf   (b_s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [39:0] d40, input logic [31:0] d32, input logic ovf32);
        exp_t e;
        e.d40   = d40;
        e.d32   = d32;
        e.ovf32 = ovf32;
        sb.push_back(e);
    endtask

    task automatic start(input logic [7:0] len);
        r_start = 1'b1;
        r_len   = len;
        tick();
        r_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        bit ok;
        ok        = 1'b0;
        r_p_valid = 1'b1;
        r_p_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = a_p_ready;
            tick();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_vec(input int stall);
        for (int i = 0; i < 50 && !a_s_valid; i++) tick();
        chk("done_wait", a_s_valid, 1);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", a_s_valid, 1);
        end
        r_s_ready = 1'b1;
        tick();
        r_s_ready = 1'b0;
        chk("idle_after_ready40", a_busy, 0);
        chk("idle_after_ready32", b_busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   {a_busy, b_busy}, 0);
        chk({tag, "_pready"}, {a_p_ready, b_p_ready}, 0);
        chk({tag, "_svalid"}, {a_s_valid, b_s_valid}, 0);
        chk({tag, "_data40"}, a_s_data, 0);
        chk({tag, "_data32"}, b_s_data, 0);
        chk({tag, "_ovf"},    {a_s_ovf, b_s_ovf}, 0);
    endtask

    // Monitor: every cycle a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (r_rst_n && a_s_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                chk("res_valid32", b_s_valid, 1);
                chk("res_data40",  a_s_data, sb[0].d40);
                chk("res_ovf40",   a_s_ovf, 0);
                chk("res_data32",  b_s_data, sb[0].d32);
                chk("res_ovf32",   b_s_ovf, sb[0].ovf32);
                if (r_s_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        r_rst_n   = 1'b0;
        r_start   = 1'b0;
        r_len     = '0;
        r_p_valid = 1'b0;
        r_p_data  = '0;
        r_s_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        r_rst_n = 1'b1;
        tick();

        // Basic vector, back-to-back beats: 100 - 50 + 7 + 0 = 57
        push(40'd57, 32'd57, 1'b0);
        start(8'd4);
        send(32'd100); send(-32'sd50); send(32'd7); send(32'd0);
        r_p_valid = 1'b0;
        chk("latency_valid", a_s_valid, 1);
        finish_vec(0);

        // Zero-length vector goes straight to DONE
        push(40'd0, 32'd0, 1'b0);
        start(8'd0);
        chk("len0_valid", a_s_valid, 1);
        chk("len0_pready", {a_p_ready, b_p_ready}, 0);
        finish_vec(0);

        // Gapped beats and a 5-cycle output stall: 5 - 3 + 1000 = 1002
        push(40'd1002, 32'd1002, 1'b0);
        start(8'd3);
        send(32'd5);    r_p_valid = 1'b0; tick(); tick();
        send(-32'sd3);  r_p_valid = 1'b0; tick();
        send(32'd1000); r_p_valid = 1'b0;
        finish_vec(5);

        // Negative sum exercises sign extension: -100 - 200 = -300
        push(40'hFF_FFFF_FED4, 32'hFFFF_FED4, 1'b0);
        start(8'd2);
        send(-32'sd100); send(-32'sd200);
        r_p_valid = 1'b0;
        finish_vec(0);

        // Positive overflow of the 32-bit accumulator
`ifdef ALM_ACC_SAT_EN
        push(40'h00_C000_0000, 32'h7FFF_FFFF, 1'b1);
`else
        push(40'h00_C000_0000, 32'hC000_0000, 1'b0);
`endif
        start(8'd3);
        send(32'h4000_0000); send(32'h4000_0000); send(32'h4000_0000);
        r_p_valid = 1'b0;
        finish_vec(0);

        // Negative overflow of the 32-bit accumulator
`ifdef ALM_ACC_SAT_EN
        push(40'hFF_0000_0000, 32'h8000_0000, 1'b1);
`else
        push(40'hFF_0000_0000, 32'h0000_0000, 1'b0);
`endif
        start(8'd2);
        send(32'h8000_0000); send(32'h8000_0000);
        r_p_valid = 1'b0;
        finish_vec(0);

        // Reset mid-vector discards the partial sum immediately
        start(8'd4);
        send(32'd1); send(32'd2);
        r_p_data = 32'd3;
        r_rst_n  = 1'b0;
        #1;
        check_zero("midreset");
        r_p_valid = 1'b0;
        @(negedge clk);
        r_rst_n = 1'b1;
        tick();
        push(40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        start(8'd1);
        send(32'hFFFF_FFFF);
        r_p_valid = 1'b0;
        finish_vec(0);

        // Start pulses during ACC and DONE are ignored: 10 + 20 = 30
        push(40'd30, 32'd30, 1'b0);
        start(8'd2);
        send(32'd10);
        r_p_valid = 1'b0;
        r_start   = 1'b1;
        r_len     = 8'd5;
        tick();
        r_start   = 1'b0;
        chk("start_in_acc_pready", a_p_ready, 1);
        send(32'd20);
        r_p_valid = 1'b0;
        chk("start_ignored_valid", a_s_valid, 1);
        r_start = 1'b1;
        r_len   = 8'd7;
        tick();
        r_start = 1'b0;
        chk("start_in_done_pready", a_p_ready, 0);
        finish_vec(1);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
